// File: rtl/mna_pkg.sv
// Shared definitions for the NoC network-adapter flit builder and receiver.
// Flit layout: {type[1:0], vc[2:0], payload[31:0]}.
package mna_pkg;

    localparam int FLIT_W = 37;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int VC_NUM = 8;
    localparam int VC_W   = 3;

    localparam int TYPE_MSB    = 36;
    localparam int TYPE_LSB    = 35;
    localparam int VC_MSB      = 34;
    localparam int VC_LSB      = 32;
    localparam int PAYLOAD_MSB = 31;

    localparam logic [1:0] FT_INV  = 2'b00;
    localparam logic [1:0] FT_HDR  = 2'b01;
    localparam logic [1:0] FT_BODY = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef enum logic [1:0] {
        WAIT_HDR  = 2'd0,
        WAIT_BODY = 2'd1,
        WAIT_TAIL = 2'd2,
        HOLD      = 2'd3
    } rx_state_t;

endpackage

// File: rtl/mna_credit_gen.sv
// Registered VC-id to one-hot credit pulse, one cycle wide per consumed flit.
// Shared by the master- and slave-side network adapters.
module mna_credit_gen #(
    parameter int VC_NUM_P = 8,
    parameter int VC_W_P   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_i,
    input  logic [VC_W_P-1:0]   vc_i,
    output logic [VC_NUM_P-1:0] credit_o
);

    localparam logic [VC_NUM_P-1:0] ONE = {{(VC_NUM_P-1){1'b0}}, 1'b1};

    logic [VC_NUM_P-1:0] credit_q;

    // One credit bit per consumed flit, cleared in every other cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
        end else if (valid_i) begin
            credit_q <= ONE << vc_i;
        end else begin
            credit_q <= '0;
        end
    end

    assign credit_o = credit_q;

endmodule

// File: rtl/mna_flit_receiver.sv
// Slave-side NoC adapter receiver: reassembles header/body/tail flits
// into one bridge request and returns a credit for every consumed flit.
module mna_flit_receiver
    import mna_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              flit_valid_i,
    output logic              flit_ready_o,
    output logic [VC_NUM-1:0] credit_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic              req_write_o,
    output logic [DATA_W-1:0] req_wdata_o,
    output logic              err_o
);

    rx_state_t         state_q;
    logic [VC_W-1:0]   vc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic              req_write_q;
    logic              err_q;

    logic [1:0]        f_type;
    logic [VC_W-1:0]   f_vc;
    logic [DATA_W-1:0] f_pay;
    logic              accept;
    logic              is_hdr;
    logic              vc_ok;

    assign f_type = flit_i[TYPE_MSB:TYPE_LSB];
    assign f_vc   = flit_i[VC_MSB:VC_LSB];
    assign f_pay  = flit_i[PAYLOAD_MSB:0];

    assign flit_ready_o = (state_q != HOLD);
    assign accept       = flit_valid_i && flit_ready_o;
    assign is_hdr       = (f_type == FT_HDR);
    assign vc_ok        = (f_vc == vc_q);

    // Packet FSM; staging regs feed the request outputs only when the tail
    // lands, so the bridge-facing fields never change outside HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_HDR;
            vc_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_write_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                WAIT_HDR: begin
                    if (accept) begin
                        if (is_hdr) begin
                            vc_q    <= f_vc;
                            addr_q  <= f_pay;
                            state_q <= WAIT_BODY;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WAIT_BODY: begin
                    if (accept) begin
                        if (f_type == FT_BODY && vc_ok) begin
                            wdata_q <= f_pay;
                            state_q <= WAIT_TAIL;
                        end else if (is_hdr) begin
                            err_q   <= 1'b1;
                            vc_q    <= f_vc;
                            addr_q  <= f_pay;
                            state_q <= WAIT_BODY;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= WAIT_HDR;
                        end
                    end
                end
                WAIT_TAIL: begin
                    if (accept) begin
                        if (f_type == FT_TAIL && vc_ok) begin
                            req_addr_q  <= addr_q;
                            req_wdata_q <= wdata_q;
                            req_write_q <= f_pay[0];
                            state_q     <= HOLD;
                        end else if (is_hdr) begin
                            err_q   <= 1'b1;
                            vc_q    <= f_vc;
                            addr_q  <= f_pay;
                            state_q <= WAIT_BODY;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= WAIT_HDR;
                        end
                    end
                end
                HOLD: begin
                    if (req_ready_i) begin
                        state_q <= WAIT_HDR;
                    end
                end
                default: state_q <= WAIT_HDR;
            endcase
        end
    end

    assign req_valid_o = (state_q == HOLD);
    assign req_addr_o  = req_addr_q;
    assign req_wdata_o = req_wdata_q;
    assign req_write_o = req_write_q;
    assign err_o       = err_q;

    mna_credit_gen #(
        .VC_NUM_P (VC_NUM),
        .VC_W_P   (VC_W)
    ) u_credit (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (accept),
        .vc_i     (f_vc),
        .credit_o (credit_o)
    );

endmodule

// File: tb/tb_mna_flit_receiver.sv
// Directed bench for mna_flit_receiver: inputs change and outputs are
// checked on the falling edge, away from the active rising edge.
module tb_mna_flit_receiver;

    logic        clk;
    logic        rst_n;
    logic [36:0] flit_i;
    logic        flit_valid_i;
    logic        flit_ready_o;
    logic [7:0]  credit_o;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic        req_write_o;
    logic [31:0] req_wdata_o;
    logic        err_o;

    int vecs;
    int errs;

    mna_flit_receiver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flit_i       (flit_i),
        .flit_valid_i (flit_valid_i),
        .flit_ready_o (flit_ready_o),
        .credit_o     (credit_o),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .req_addr_o   (req_addr_o),
        .req_write_o  (req_write_o),
        .req_wdata_o  (req_wdata_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [36:0] mk(input logic [1:0] t,
                                       input logic [2:0] vc,
                                       input logic [31:0] p);
        return {t, vc, p};
    endfunction

    task automatic drv(input logic v, input logic [36:0] f);
        flit_valid_i = v;
        flit_i       = f;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        flit_valid_i = 1'b0;
        flit_i       = '0;
        req_ready_i  = 1'b1;
        @(negedge clk);
        vecs++;
        if ({flit_ready_o, req_valid_o, credit_o, err_o} !== 11'b1_0_00000000_0) begin
            errs++;
            $display("FAIL reset_ctl: got rdy=%b val=%b cr=%h err=%b want 1 0 00 0",
                     flit_ready_o, req_valid_o, credit_o, err_o);
        end
        vecs++;
        if ({req_addr_o, req_write_o, req_wdata_o} !== 65'd0) begin
            errs++;
            $display("FAIL reset_data: got addr=%h w=%b wd=%h want zeros",
                     req_addr_o, req_write_o, req_wdata_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        req_ready_i = 1'b1;
        drv(1'b1, mk(2'b01, 3'd7, 32'h0000_1000));
        vecs++;
        if (credit_o !== 8'h80 || err_o !== 1'b0) begin
            errs++;
            $display("FAIL wr_hdr_credit: got cr=%h err=%b want 80 0", credit_o, err_o);
        end
        drv(1'b1, mk(2'b10, 3'd7, 32'hDEAD_BEEF));
        vecs++;
        if (credit_o !== 8'h80 || req_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL wr_body_credit: got cr=%h val=%b want 80 0", credit_o, req_valid_o);
        end
        drv(1'b1, mk(2'b11, 3'd7, 32'h0000_0001));
        vecs++;
        if (credit_o !== 8'h80 || req_valid_o !== 1'b1) begin
            errs++;
            $display("FAIL wr_tail: got cr=%h val=%b want 80 1", credit_o, req_valid_o);
        end
        vecs++;
        if (req_addr_o !== 32'h1000 || req_write_o !== 1'b1 || req_wdata_o !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL wr_fields: got %h %b %h want 00001000 1 deadbeef",
                     req_addr_o, req_write_o, req_wdata_o);
        end
        drv(1'b0, '0);
        vecs++;
        if (req_valid_o !== 1'b0 || credit_o !== 8'h00) begin
            errs++;
            $display("FAIL wr_done: got val=%b cr=%h want 0 00", req_valid_o, credit_o);
        end
    endtask

    task automatic test_backpressure;
        req_ready_i = 1'b0;
        drv(1'b1, mk(2'b01, 3'd1, 32'h0000_2000));
        vecs++;
        if (req_addr_o !== 32'h1000 || credit_o !== 8'h02) begin
            errs++;
            $display("FAIL bp_hold_prev: got addr=%h cr=%h want 00001000 02", req_addr_o, credit_o);
        end
        drv(1'b1, mk(2'b10, 3'd1, 32'h1234_5678));
        drv(1'b1, mk(2'b11, 3'd1, 32'h0000_0000));
        vecs++;
        if (req_valid_o !== 1'b1 || credit_o !== 8'h02 ||
            req_addr_o !== 32'h2000 || req_write_o !== 1'b0 || req_wdata_o !== 32'h1234_5678) begin
            errs++;
            $display("FAIL bp_req: got val=%b cr=%h %h %b %h want 1 02 00002000 0 12345678",
                     req_valid_o, credit_o, req_addr_o, req_write_o, req_wdata_o);
        end
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, mk(2'b01, 3'd5, 32'h0000_9000));
            vecs++;
            if (req_valid_o !== 1'b1 || flit_ready_o !== 1'b0 || credit_o !== 8'h00 ||
                req_addr_o !== 32'h2000 || req_write_o !== 1'b0 || req_wdata_o !== 32'h1234_5678) begin
                errs++;
                $display("FAIL bp_stall%0d: got val=%b rdy=%b cr=%h %h %b %h want 1 0 00 00002000 0 12345678",
                         i, req_valid_o, flit_ready_o, credit_o, req_addr_o, req_write_o, req_wdata_o);
            end
        end
        req_ready_i = 1'b1;
        drv(1'b1, mk(2'b01, 3'd5, 32'h0000_9000));
        vecs++;
        if (req_valid_o !== 1'b0 || credit_o !== 8'h00 || flit_ready_o !== 1'b1) begin
            errs++;
            $display("FAIL bp_release: got val=%b cr=%h rdy=%b want 0 00 1",
                     req_valid_o, credit_o, flit_ready_o);
        end
        drv(1'b0, '0);
    endtask

    task automatic test_vc_mismatch;
        req_ready_i = 1'b1;
        drv(1'b1, mk(2'b01, 3'd2, 32'h0000_3000));
        vecs++;
        if (credit_o !== 8'h04 || err_o !== 1'b0) begin
            errs++;
            $display("FAIL vc_hdr: got cr=%h err=%b want 04 0", credit_o, err_o);
        end
        drv(1'b1, mk(2'b10, 3'd3, 32'h5555_5555));
        vecs++;
        if (credit_o !== 8'h08 || err_o !== 1'b1) begin
            errs++;
            $display("FAIL vc_body: got cr=%h err=%b want 08 1", credit_o, err_o);
        end
        drv(1'b1, mk(2'b11, 3'd2, 32'h0000_0001));
        vecs++;
        if (err_o !== 1'b1 || credit_o !== 8'h04 || req_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL vc_state: got err=%b cr=%h val=%b want 1 04 0",
                     err_o, credit_o, req_valid_o);
        end
        drv(1'b0, '0);
        vecs++;
        if (err_o !== 1'b0 || req_valid_o !== 1'b0 || credit_o !== 8'h00) begin
            errs++;
            $display("FAIL vc_idle: got err=%b val=%b cr=%h want 0 0 00",
                     err_o, req_valid_o, credit_o);
        end
    endtask

    task automatic test_hdr_in_tail;
        req_ready_i = 1'b1;
        drv(1'b1, mk(2'b01, 3'd4, 32'h0000_4000));
        drv(1'b1, mk(2'b10, 3'd4, 32'hAAAA_5555));
        drv(1'b1, mk(2'b01, 3'd4, 32'h0000_5000));
        vecs++;
        if (err_o !== 1'b1 || credit_o !== 8'h10) begin
            errs++;
            $display("FAIL hit_err: got err=%b cr=%h want 1 10", err_o, credit_o);
        end
        drv(1'b1, mk(2'b10, 3'd4, 32'h0BAD_F00D));
        vecs++;
        if (err_o !== 1'b0 || credit_o !== 8'h10) begin
            errs++;
            $display("FAIL hit_body: got err=%b cr=%h want 0 10", err_o, credit_o);
        end
        drv(1'b1, mk(2'b11, 3'd4, 32'hFFFF_FFFF));
        vecs++;
        if (req_valid_o !== 1'b1 || req_addr_o !== 32'h5000 ||
            req_wdata_o !== 32'h0BAD_F00D || req_write_o !== 1'b1) begin
            errs++;
            $display("FAIL hit_req: got val=%b %h %h %b want 1 00005000 0badf00d 1",
                     req_valid_o, req_addr_o, req_wdata_o, req_write_o);
        end
        drv(1'b0, '0);
    endtask

    task automatic test_invalid;
        drv(1'b1, mk(2'b00, 3'd6, 32'h1111_1111));
        vecs++;
        if (err_o !== 1'b1 || credit_o !== 8'h40 || req_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL inv_type: got err=%b cr=%h val=%b want 1 40 0",
                     err_o, credit_o, req_valid_o);
        end
        drv(1'b1, mk(2'b10, 3'd6, 32'h2222_2222));
        vecs++;
        if (err_o !== 1'b1 || credit_o !== 8'h40) begin
            errs++;
            $display("FAIL inv_still_hdr: got err=%b cr=%h want 1 40", err_o, credit_o);
        end
        drv(1'b0, '0);
        vecs++;
        if (err_o !== 1'b0 || credit_o !== 8'h00) begin
            errs++;
            $display("FAIL inv_idle: got err=%b cr=%h want 0 00", err_o, credit_o);
        end
    endtask

    task automatic test_reset_mid;
        req_ready_i = 1'b1;
        drv(1'b1, mk(2'b01, 3'd0, 32'h0000_6000));
        drv(1'b1, mk(2'b10, 3'd0, 32'h3333_3333));
        flit_valid_i = 1'b0;
        rst_n        = 1'b0;
        #1;
        vecs++;
        if (req_valid_o !== 1'b0 || credit_o !== 8'h00 || err_o !== 1'b0 ||
            req_addr_o !== 32'h0 || req_wdata_o !== 32'h0 || req_write_o !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid: got val=%b cr=%h err=%b %h %h %b want 0 00 0 0 0 0",
                     req_valid_o, credit_o, err_o, req_addr_o, req_wdata_o, req_write_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drv(1'b1, mk(2'b01, 3'd3, 32'h0000_7000));
        vecs++;
        if (err_o !== 1'b0 || credit_o !== 8'h08) begin
            errs++;
            $display("FAIL rst_new_hdr: got err=%b cr=%h want 0 08", err_o, credit_o);
        end
        drv(1'b1, mk(2'b10, 3'd3, 32'hCAFE_BABE));
        drv(1'b1, mk(2'b11, 3'd3, 32'h0000_0001));
        vecs++;
        if (req_valid_o !== 1'b1 || req_addr_o !== 32'h7000 ||
            req_wdata_o !== 32'hCAFE_BABE || req_write_o !== 1'b1 || credit_o !== 8'h08) begin
            errs++;
            $display("FAIL rst_new_req: got val=%b %h %h %b cr=%h want 1 00007000 cafebabe 1 08",
                     req_valid_o, req_addr_o, req_wdata_o, req_write_o, credit_o);
        end
        drv(1'b0, '0);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_write();
        test_backpressure();
        test_vc_mismatch();
        test_hdr_in_tail();
        test_invalid();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
